// File: rtl/axi_time_pkg.sv
// Shared types and helpers for the axi_time sync controller and its timer.
`default_nettype none

package axi_time_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_WAIT = 3'd3,
    ST_SOFT = 3'd4,
    ST_DONE = 3'd5,
    ST_FAIL = 3'd6
  } sync_ctrl_state_t;

  // A loaded value of TIMER_INFINITE_VAL never expires; expiry fires while the
  // count still reads TIMER_EXPIRE_VAL, i.e. on the cycle it would reach zero.
  localparam int unsigned TIMER_INFINITE_VAL = 0;
  localparam int unsigned TIMER_EXPIRE_VAL   = 1;

  function automatic sync_ctrl_state_t sync_entry_state(input logic ext_en);
    return ext_en ? ST_ARM : ST_SOFT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_time_sync_timer.sv
// Loadable per-attempt down-counter; a zero load selects wait-forever mode.
`default_nettype none

module axi_time_sync_timer
  import axi_time_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_tick,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;
  logic             r_inf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
      r_inf   <= 1'b0;
    end else if (i_load) begin
      r_count <= i_value;
      r_inf   <= (i_value == WIDTH'(TIMER_INFINITE_VAL));
    end else if (i_tick && !r_inf && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_tick && !r_inf && (r_count == WIDTH'(TIMER_EXPIRE_VAL));

endmodule

`default_nettype wire

// File: rtl/axi_time_sync_ctrl.sv
// Load / sync sequencer for the axi_time counter with timeout and retries.
// Optional: AXI_TIME_SYNC_CTRL_STAMP_EN captures time_counter on completion.
`default_nettype none

module axi_time_sync_ctrl
  import axi_time_pkg::*;
#(
  parameter int COUNT_WIDTH   = 64,
  parameter int TIMEOUT_WIDTH = 32,
  parameter int RETRY_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_enable,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic                     cfg_load_en,
  input  logic                     cfg_ext_en,
  input  logic [COUNT_WIDTH-1:0]   cfg_time_value,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic [RETRY_WIDTH-1:0]   cfg_retries,
  input  logic                     ext_sync_pulse,
  input  logic [COUNT_WIDTH-1:0]   time_counter,
  input  logic                     time_overwrite_ready,
  output logic                     time_enable,
  output logic                     time_overwrite_valid,
  output logic [COUNT_WIDTH-1:0]   time_overwrite,
  output logic                     time_sync_ext,
  output logic                     time_sync_soft,
  output logic                     busy,
  output logic                     done,
  output logic                     status_timeout,
  output logic                     status_aborted,
  output logic [RETRY_WIDTH:0]     attempts,
  output logic                     stamp_valid,
  output logic [COUNT_WIDTH-1:0]   stamp
);

  sync_ctrl_state_t         r_state, w_next;
  logic                     r_enable;
  logic                     r_load_en, r_ext_en;
  logic [COUNT_WIDTH-1:0]   r_value;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic [RETRY_WIDTH-1:0]   r_retries;
  logic [RETRY_WIDTH:0]     r_attempts;
  logic                     r_st_timeout, r_st_aborted;
  logic                     w_start_ok, w_abort, w_expire;

  assign w_start_ok = (r_state == ST_IDLE) && cfg_start && cfg_enable;
  assign w_abort    = (r_state != ST_IDLE) && cfg_abort;

  axi_time_sync_timer #(.WIDTH(TIMEOUT_WIDTH)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (r_state == ST_ARM),
    .i_value  (r_timeout),
    .i_tick   (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start_ok) w_next = cfg_load_en ? ST_LOAD : sync_entry_state(cfg_ext_en);
      ST_LOAD: if (time_overwrite_ready) w_next = sync_entry_state(r_ext_en);
      ST_ARM:  w_next = ext_sync_pulse ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        // A pulse on the expiry cycle still wins over the timeout.
        if (ext_sync_pulse) w_next = ST_DONE;
        else if (w_expire)  w_next = (r_attempts <= {1'b0, r_retries}) ? ST_ARM : ST_FAIL;
      end
      ST_SOFT: w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      ST_FAIL: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_enable     <= 1'b0;
      r_load_en    <= 1'b0;
      r_ext_en     <= 1'b0;
      r_value      <= '0;
      r_timeout    <= '0;
      r_retries    <= '0;
      r_attempts   <= '0;
      r_st_timeout <= 1'b0;
      r_st_aborted <= 1'b0;
    end else begin
      r_enable <= cfg_enable;
      if (w_start_ok) begin
        r_load_en    <= cfg_load_en;
        r_ext_en     <= cfg_ext_en;
        r_value      <= cfg_time_value;
        r_timeout    <= cfg_timeout;
        r_retries    <= cfg_retries;
        r_attempts   <= '0;
        r_st_timeout <= 1'b0;
        r_st_aborted <= 1'b0;
      end
      if (r_state == ST_ARM)  r_attempts   <= r_attempts + 1'b1;
      if (r_state == ST_FAIL) r_st_timeout <= 1'b1;
      if (w_abort)            r_st_aborted <= 1'b1;
    end
  end

  assign time_enable          = r_enable;
  assign time_overwrite_valid = (r_state == ST_LOAD);
  assign time_overwrite       = (r_state == ST_LOAD) ? r_value : '0;
  assign time_sync_ext        = (r_state == ST_ARM) || (r_state == ST_WAIT);
  assign time_sync_soft       = (r_state == ST_SOFT);
  assign busy                 = (r_state != ST_IDLE);
  assign done                 = (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign status_timeout       = r_st_timeout;
  assign status_aborted       = r_st_aborted;
  assign attempts             = r_attempts;

`ifdef AXI_TIME_SYNC_CTRL_STAMP_EN
  logic [COUNT_WIDTH-1:0] r_stamp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 r_stamp <= '0;
    else if (r_state == ST_DONE) r_stamp <= time_counter;
  end

  assign stamp_valid = (r_state == ST_DONE);
  assign stamp       = (r_state == ST_DONE) ? time_counter : r_stamp;
`else
  logic w_unused_counter;
  assign w_unused_counter = ^time_counter;
  assign stamp_valid      = 1'b0;
  assign stamp            = '0;
`endif

endmodule

`default_nettype wire
